// File: rtl/mem_write_arbi_rr.sv
// N-channel burst write arbiter: one-cycle grant search (round-robin or fixed
// priority) in front of a single memory-controller write port, with a watchdog.
module mem_write_arbi_rr #(
    parameter int CH_NUM        = 4,
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24,
    parameter int LEN_BITS      = 10,
    parameter int ARB_MODE      = 0,
    parameter int TIMEOUT       = 8000
) (
    input  logic                            mem_clk,
    input  logic                            rst_n,
    input  logic [CH_NUM-1:0]               ch_wr_burst_req,
    input  logic [CH_NUM*LEN_BITS-1:0]      ch_wr_burst_len,
    input  logic [CH_NUM*ADDR_BITS-1:0]     ch_wr_burst_addr,
    input  logic [CH_NUM*MEM_DATA_BITS-1:0] ch_wr_burst_data,
    output logic [CH_NUM-1:0]               ch_wr_burst_data_req,
    output logic [CH_NUM-1:0]               ch_wr_burst_finish,
    output logic [CH_NUM-1:0]               ch_wr_burst_timeout,
    output logic [CH_NUM-1:0]               wr_grant,
    output logic                            wr_burst_req,
    output logic [LEN_BITS-1:0]             wr_burst_len,
    output logic [ADDR_BITS-1:0]            wr_burst_addr,
    input  logic                            wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0]        wr_burst_data,
    input  logic                            wr_burst_finish
);
    localparam int IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_BEGIN = 3'd2,
        S_WRITE = 3'd3,
        S_END   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IW-1:0]          r_g;
    logic [IW-1:0]          r_ptr;
    logic [1:0]             r_fin_pipe;
    logic [CW-1:0]          r_wd_cnt;
    logic [CH_NUM-1:0]      r_grant;
    logic [CH_NUM-1:0]      r_ch_finish;
    logic [CH_NUM-1:0]      r_ch_timeout;
    logic                   r_wr_burst_req;
    logic [LEN_BITS-1:0]    r_len;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [CH_NUM-1:0]      w_elig;
    logic [IW-1:0]          w_cand;
    logic [IW-1:0]          w_win_idx;
    logic                   w_win_found;
    logic                   w_fin_hit;
    logic                   w_tmo_hit;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned step);
        int unsigned sum;
        sum = 32'(base) + step;
        if (sum >= CH_NUM) begin
            sum = sum - CH_NUM;
        end else begin
            sum = sum;
        end
        return sum[IW-1:0];
    endfunction

    function automatic logic [CH_NUM-1:0] onehot(input logic [IW-1:0] idx);
        logic [CH_NUM-1:0] v;
        v = {CH_NUM{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Eligibility and single-cycle winner search (first eligible from the start point).
    always_comb begin
        w_elig      = {CH_NUM{1'b0}};
        w_cand      = {IW{1'b0}};
        w_win_idx   = {IW{1'b0}};
        w_win_found = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            w_elig[i] = ch_wr_burst_req[i] && (ch_wr_burst_len[i*LEN_BITS +: LEN_BITS] != {LEN_BITS{1'b0}});
        end
        for (int k = 0; k < CH_NUM; k++) begin
            if (ARB_MODE == 1) begin
                w_cand = IW'(k);
            end else begin
                w_cand = wrap_idx(r_ptr, 32'(k));
            end
            if (!w_win_found && w_elig[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end else begin
                w_win_found = w_win_found;
            end
        end
    end

    // A finish that coincides with the watchdog limit wins over the timeout.
    always_comb begin
        w_fin_hit = (r_state == S_WRITE) && r_fin_pipe[1];
        w_tmo_hit = (r_state == S_WRITE) && !r_fin_pipe[1] && (r_wd_cnt == CW'(TIMEOUT));
    end

    // FSM state register.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_ARB;
            S_ARB:   w_state_nxt = w_win_found ? S_BEGIN : S_ARB;
            S_BEGIN: w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = (w_fin_hit || w_tmo_hit) ? S_END : S_WRITE;
            S_END:   w_state_nxt = S_ARB;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant, burst command, finish pipe, watchdog and per-channel pulses.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g            <= {IW{1'b0}};
            r_ptr          <= {IW{1'b0}};
            r_fin_pipe     <= 2'b00;
            r_wd_cnt       <= {CW{1'b0}};
            r_grant        <= {CH_NUM{1'b0}};
            r_ch_finish    <= {CH_NUM{1'b0}};
            r_ch_timeout   <= {CH_NUM{1'b0}};
            r_wr_burst_req <= 1'b0;
            r_len          <= {LEN_BITS{1'b0}};
            r_addr         <= {ADDR_BITS{1'b0}};
        end else begin
            r_fin_pipe   <= {r_fin_pipe[0], wr_burst_finish};
            r_ch_finish  <= {CH_NUM{1'b0}};
            r_ch_timeout <= {CH_NUM{1'b0}};
            if ((r_state == S_BEGIN) || (r_state == S_WRITE)) begin
                r_wd_cnt <= r_wd_cnt + CW'(1);
            end else begin
                r_wd_cnt <= {CW{1'b0}};
            end
            case (r_state)
                S_ARB: begin
                    if (w_win_found) begin
                        r_g     <= w_win_idx;
                        r_grant <= onehot(w_win_idx);
                    end else begin
                        r_grant <= {CH_NUM{1'b0}};
                    end
                end
                S_BEGIN: begin
                    r_len          <= ch_wr_burst_len[r_g*LEN_BITS +: LEN_BITS];
                    r_addr         <= ch_wr_burst_addr[r_g*ADDR_BITS +: ADDR_BITS];
                    r_wr_burst_req <= 1'b1;
                end
                S_WRITE: begin
                    if (r_wr_burst_req && (wr_burst_data_req || w_tmo_hit)) begin
                        r_wr_burst_req <= 1'b0;
                    end else begin
                        r_wr_burst_req <= r_wr_burst_req;
                    end
                    if (w_fin_hit || w_tmo_hit) begin
                        r_ch_finish  <= onehot(r_g);
                        r_ch_timeout <= w_tmo_hit ? onehot(r_g) : {CH_NUM{1'b0}};
                    end else begin
                        r_ch_finish  <= {CH_NUM{1'b0}};
                    end
                end
                S_END: begin
                    r_ptr   <= wrap_idx(r_g, 32'd1);
                    r_grant <= {CH_NUM{1'b0}};
                end
                default: begin
                    r_grant <= r_grant;
                end
            endcase
        end
    end

    // Data strobe and write data follow the owner only while the burst is open.
    always_comb begin
        ch_wr_burst_data_req = {CH_NUM{1'b0}};
        wr_burst_data        = {MEM_DATA_BITS{1'b0}};
        if (r_state == S_WRITE) begin
            ch_wr_burst_data_req[r_g] = wr_burst_data_req;
            wr_burst_data             = ch_wr_burst_data[r_g*MEM_DATA_BITS +: MEM_DATA_BITS];
        end else begin
            wr_burst_data = {MEM_DATA_BITS{1'b0}};
        end
    end

    assign ch_wr_burst_finish  = r_ch_finish;
    assign ch_wr_burst_timeout = r_ch_timeout;
    assign wr_grant            = r_grant;
    assign wr_burst_req        = r_wr_burst_req;
    assign wr_burst_len        = r_len;
    assign wr_burst_addr       = r_addr;

endmodule

// File: tb/tb_mem_write_arbi_rr.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one stimulus
// stream; the bench plays the memory controller.
module tb_mem_write_arbi_rr;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 24;
    localparam int LW = 10;

    logic            mem_clk = 1'b0;
    logic            rst_n   = 1'b0;
    logic [N-1:0]    ch_req  = 4'b0000;
    logic [N*LW-1:0] ch_len;
    logic [N*AW-1:0] ch_addr;
    logic [N*DW-1:0] ch_data;
    logic            wr_burst_data_req = 1'b0;
    logic            wr_burst_finish   = 1'b0;

    logic [LW-1:0] chlen  [N];
    logic [AW-1:0] chaddr [N];
    logic [DW-1:0] chdata [N];

    logic [N-1:0]  rr_ch_data_req, rr_ch_finish, rr_ch_timeout, rr_wr_grant;
    logic          rr_wr_burst_req;
    logic [LW-1:0] rr_wr_burst_len;
    logic [AW-1:0] rr_wr_burst_addr;
    logic [DW-1:0] rr_wr_burst_data;
    logic [N-1:0]  fp_ch_data_req, fp_ch_finish, fp_ch_timeout, fp_wr_grant;
    logic          fp_wr_burst_req;
    logic [LW-1:0] fp_wr_burst_len;
    logic [AW-1:0] fp_wr_burst_addr;
    logic [DW-1:0] fp_wr_burst_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 mem_clk = ~mem_clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch_len[i*LW +: LW]  = chlen[i];
            ch_addr[i*AW +: AW] = chaddr[i];
            ch_data[i*DW +: DW] = chdata[i];
        end
    end

    mem_write_arbi_rr #(.CH_NUM(N), .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW),
                        .ARB_MODE(0), .TIMEOUT(100)) u_rr (
        .mem_clk(mem_clk), .rst_n(rst_n),
        .ch_wr_burst_req(ch_req), .ch_wr_burst_len(ch_len),
        .ch_wr_burst_addr(ch_addr), .ch_wr_burst_data(ch_data),
        .ch_wr_burst_data_req(rr_ch_data_req), .ch_wr_burst_finish(rr_ch_finish),
        .ch_wr_burst_timeout(rr_ch_timeout), .wr_grant(rr_wr_grant),
        .wr_burst_req(rr_wr_burst_req), .wr_burst_len(rr_wr_burst_len),
        .wr_burst_addr(rr_wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_data(rr_wr_burst_data), .wr_burst_finish(wr_burst_finish)
    );

    mem_write_arbi_rr #(.CH_NUM(N), .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW),
                        .ARB_MODE(1), .TIMEOUT(100)) u_fp (
        .mem_clk(mem_clk), .rst_n(rst_n),
        .ch_wr_burst_req(ch_req), .ch_wr_burst_len(ch_len),
        .ch_wr_burst_addr(ch_addr), .ch_wr_burst_data(ch_data),
        .ch_wr_burst_data_req(fp_ch_data_req), .ch_wr_burst_finish(fp_ch_finish),
        .ch_wr_burst_timeout(fp_ch_timeout), .wr_grant(fp_wr_grant),
        .wr_burst_req(fp_wr_burst_req), .wr_burst_len(fp_wr_burst_len),
        .wr_burst_addr(fp_wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_data(fp_wr_burst_data), .wr_burst_finish(wr_burst_finish)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the round-robin instance to raise its burst request.
    task automatic wait_req(output int n);
        n = 0;
        while (rr_wr_burst_req !== 1'b1 && n < 20) begin
            @(negedge mem_clk);
            n++;
        end
        chk("burst_start_rr", {63'd0, rr_wr_burst_req}, 64'd1);
        chk("burst_start_fp", {63'd0, fp_wr_burst_req}, 64'd1);
    endtask

    // One short burst: one data strobe, one finish pulse, then the finish handshake.
    task automatic run_burst(input string tag, input logic [N-1:0] exp_rr, input logic [N-1:0] exp_fp,
                             output int n);
        logic [DW-1:0] exp_data = 64'd0;
        logic [AW-1:0] exp_addr = 24'd0;
        wait_req(n);
        chk({tag, "_grant_rr"}, {60'd0, rr_wr_grant}, {60'd0, exp_rr});
        chk({tag, "_grant_fp"}, {60'd0, fp_wr_grant}, {60'd0, exp_fp});
        for (int i = 0; i < N; i++) begin
            if (exp_rr[i]) begin
                exp_data = chdata[i];
                exp_addr = chaddr[i];
            end
        end
        chk({tag, "_addr_rr"}, {40'd0, rr_wr_burst_addr}, {40'd0, exp_addr});
        wr_burst_data_req = 1'b1;
        #1;
        chk({tag, "_dreq_rr"}, {60'd0, rr_ch_data_req}, {60'd0, exp_rr});
        chk({tag, "_data_rr"}, rr_wr_burst_data, exp_data);
        @(negedge mem_clk);
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b1;
        @(negedge mem_clk);
        wr_burst_finish = 1'b0;
        @(negedge mem_clk);
        @(negedge mem_clk);
        chk({tag, "_finish_rr"}, {60'd0, rr_ch_finish}, {60'd0, exp_rr});
        chk({tag, "_finish_fp"}, {60'd0, fp_ch_finish}, {60'd0, exp_fp});
        chk({tag, "_tmo_rr"}, {60'd0, rr_ch_timeout}, 64'd0);
        @(negedge mem_clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        chlen[0] = 10'd4;  chaddr[0] = 24'h000100; chdata[0] = 64'hA5A5_0000_0000_0000;
        chlen[1] = 10'd4;  chaddr[1] = 24'h000200; chdata[1] = 64'hA5A5_0000_0000_1111;
        chlen[2] = 10'd16; chaddr[2] = 24'h001000; chdata[2] = 64'hA5A5_0000_0000_2222;
        chlen[3] = 10'd4;  chaddr[3] = 24'h000300; chdata[3] = 64'hA5A5_0000_0000_3333;

        // Reset state
        @(negedge mem_clk);
        chk("rst_grant", {60'd0, rr_wr_grant}, 64'd0);
        chk("rst_req", {63'd0, rr_wr_burst_req}, 64'd0);
        chk("rst_len", {54'd0, rr_wr_burst_len}, 64'd0);
        chk("rst_addr", {40'd0, rr_wr_burst_addr}, 64'd0);
        chk("rst_data", rr_wr_burst_data, 64'd0);
        chk("rst_finish", {60'd0, rr_ch_finish}, 64'd0);
        chk("rst_tmo", {60'd0, rr_ch_timeout}, 64'd0);
        chk("rst_grant_fp", {60'd0, fp_wr_grant}, 64'd0);
        @(negedge mem_clk);
        rst_n = 1'b1;

        // Round-robin fairness with every channel requesting
        ch_req = 4'b1111;
        run_burst("rr0", 4'b0001, 4'b0001, n);
        run_burst("rr1", 4'b0010, 4'b0001, n);
        run_burst("rr2", 4'b0100, 4'b0001, n);
        run_burst("rr3", 4'b1000, 4'b0001, n);
        run_burst("rr4", 4'b0001, 4'b0001, n);
        run_burst("rr5", 4'b0010, 4'b0001, n);

        // Lone ch1: granted every round with the minimum END+ARB gap
        ch_req = 4'b0010;
        for (int r = 0; r < 3; r++) begin
            run_burst("solo1", 4'b0010, 4'b0010, n);
            chk("solo1_latency", 64'(n), 64'd2);
        end

        // Zero length is never eligible
        chlen[1] = 10'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge mem_clk);
            chk("zlen_req", {63'd0, rr_wr_burst_req}, 64'd0);
            chk("zlen_grant", {60'd0, rr_wr_grant}, 64'd0);
        end
        chk("zlen_grant_fp", {60'd0, fp_wr_grant}, 64'd0);
        ch_req   = 4'b0000;
        chlen[1] = 10'd4;

        // Single channel 2, 16 strobes
        @(negedge mem_clk);
        ch_req = 4'b0100;
        @(negedge mem_clk);
        chk("single_grant", {60'd0, rr_wr_grant}, 64'h4);
        chk("single_req_early", {63'd0, rr_wr_burst_req}, 64'd0);
        @(negedge mem_clk);
        chk("single_req", {63'd0, rr_wr_burst_req}, 64'd1);
        chk("single_len", {54'd0, rr_wr_burst_len}, 64'd16);
        chk("single_addr", {40'd0, rr_wr_burst_addr}, 64'h001000);
        ch_req = 4'b0000;
        for (int s = 0; s < 16; s++) begin
            wr_burst_data_req = 1'b1;
            #1;
            chk("single_dreq_rr", {60'd0, rr_ch_data_req}, 64'h4);
            chk("single_dreq_fp", {60'd0, fp_ch_data_req}, 64'h4);
            chk("single_data", rr_wr_burst_data, 64'hA5A5_0000_0000_2222);
            @(negedge mem_clk);
        end
        wr_burst_data_req = 1'b0;
        #1;
        chk("single_dreq_off", {60'd0, rr_ch_data_req}, 64'd0);
        chk("single_req_clr", {63'd0, rr_wr_burst_req}, 64'd0);
        wr_burst_finish = 1'b1;
        @(negedge mem_clk);
        wr_burst_finish = 1'b0;
        chk("single_fin_f0", {60'd0, rr_ch_finish}, 64'd0);
        @(negedge mem_clk);
        chk("single_fin_f1", {60'd0, rr_ch_finish}, 64'd0);
        @(negedge mem_clk);
        chk("single_fin_f2", {60'd0, rr_ch_finish}, 64'h4);
        chk("single_grant_end", {60'd0, rr_wr_grant}, 64'h4);
        @(negedge mem_clk);
        chk("single_fin_f3", {60'd0, rr_ch_finish}, 64'd0);
        chk("single_grant_off", {60'd0, rr_wr_grant}, 64'd0);

        // Fixed priority: ch0 beats ch3 until ch0 drops
        ch_req = 4'b1001;
        run_burst("fp0", 4'b1000, 4'b0001, n);
        run_burst("fp1", 4'b0001, 4'b0001, n);
        run_burst("fp2", 4'b1000, 4'b0001, n);
        ch_req = 4'b1000;
        run_burst("fp3", 4'b1000, 4'b1000, n);

        // Watchdog: the controller never strobes or finishes
        ch_req = 4'b0011;
        wait_req(n);
        cnt = 0;
        while (rr_ch_timeout === 4'b0000 && cnt < 150) begin
            @(negedge mem_clk);
            cnt++;
        end
        chk("tmo_cycles", 64'(cnt), 64'd100);
        chk("tmo_pulse_rr", {60'd0, rr_ch_timeout}, 64'h1);
        chk("tmo_finish_rr", {60'd0, rr_ch_finish}, 64'h1);
        chk("tmo_pulse_fp", {60'd0, fp_ch_timeout}, 64'h1);
        chk("tmo_req_clr", {63'd0, rr_wr_burst_req}, 64'd0);
        run_burst("tmo_resume", 4'b0010, 4'b0001, n);

        // Asynchronous reset in the middle of a burst
        ch_req = 4'b0100;
        wait_req(n);
        wr_burst_data_req = 1'b1;
        wr_burst_finish   = 1'b1;
        @(negedge mem_clk);
        wr_burst_finish = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_grant", {60'd0, rr_wr_grant}, 64'd0);
        chk("mrst_req", {63'd0, rr_wr_burst_req}, 64'd0);
        chk("mrst_len", {54'd0, rr_wr_burst_len}, 64'd0);
        chk("mrst_addr", {40'd0, rr_wr_burst_addr}, 64'd0);
        chk("mrst_data", rr_wr_burst_data, 64'd0);
        chk("mrst_dreq", {60'd0, rr_ch_data_req}, 64'd0);
        chk("mrst_grant_fp", {60'd0, fp_wr_grant}, 64'd0);
        wr_burst_data_req = 1'b0;
        ch_req = 4'b1111;
        @(negedge mem_clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge mem_clk);
            chk("mrst_no_stale_fin", {60'd0, rr_ch_finish}, 64'd0);
        end
        run_burst("mrst_first", 4'b0001, 4'b0001, n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
